cpu_clk_ctrl: RTL and testbench

Run/pause/single-step and speed controller for the pipeline CPU.
- Produces a one-cycle clock-enable pulse (cpu_ce) at 1, 0.5, 0.25 or 0.125 Hz of the board clock, plus a CPU reset request.
- Sits between the board switches/buttons and the CPU, so the whole design runs on one clock.
- Replaces per-rate divided clocks with a single enable.

---
 rtl/cpu_clk_ctrl_if.sv | 23 ++
 rtl/cpu_clk_ctrl.sv | 163 ++++++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_clk_ctrl_if.sv
// Switch/button inputs and CPU-facing control outputs of the clock-enable controller.
// master drives the raw switches and observes the outputs; slave is the controller side.
interface cpu_clk_ctrl_if;
    logic        sw_go;
    logic        sw_rst;
    logic        sw_speed;
    logic        btn_step;
    logic        cpu_ce;
    logic        cpu_rst;
    logic [1:0]  speed_sel;
    logic        running;
    logic [31:0] ce_count;

    modport master (
        output sw_go, sw_rst, sw_speed, btn_step,
        input  cpu_ce, cpu_rst, speed_sel, running, ce_count
    );

    modport slave (
        input  sw_go, sw_rst, sw_speed, btn_step,
        output cpu_ce, cpu_rst, speed_sel, running, ce_count
    );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// Run/pause/step and speed controller emitting a one-cycle CPU clock enable; CPU_CE_COUNT_EN adds a pulse counter.
// cpu_ce/cpu_rst are registered one cycle after their cause; no backpressure, the enable is free-running.
module cpu_clk_ctrl #(
    parameter int BASE_DIV   = 100_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    cpu_clk_ctrl_if.slave    bus
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2
    } state_t;

    // Input bit order: 0 go, 1 rst, 2 speed, 3 step.
    logic [3:0]    raw;
    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [3:0]    lvl_q, lvl_d;
    logic [1:0]    lvl_prev_q, lvl_prev_d;
    logic [DW-1:0] deb_cnt_q [4];
    logic [DW-1:0] deb_cnt_d [4];

    state_t        state_q, state_d;
    logic [31:0]   presc_q, presc_d;
    logic [1:0]    speed_sel_q, speed_sel_d;
    logic          cpu_ce_q, cpu_ce_d;
    logic          cpu_rst_q, cpu_rst_d;
    logic          running_q, running_d;

    logic          go_lvl, rst_lvl, spd_rise, step_rise;
    logic [31:0]   divisor;
    logic          term;

    assign raw = {bus.btn_step, bus.sw_speed, bus.sw_rst, bus.sw_go};

    always_comb begin
        sync1_d    = raw;
        sync2_d    = sync1_q;
        lvl_d      = lvl_q;
        lvl_prev_d = lvl_q[3:2];
        for (int i = 0; i < 4; i++) begin
            deb_cnt_d[i] = '0;
            // Any sample agreeing with the accepted level restarts the count.
            if (sync2_q[i] != lvl_q[i]) begin
                if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
                    lvl_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign go_lvl    = lvl_q[0];
    assign rst_lvl   = lvl_q[1];
    assign spd_rise  = lvl_q[2] & ~lvl_prev_q[0];
    assign step_rise = lvl_q[3] & ~lvl_prev_q[1];

    assign divisor = 32'(BASE_DIV) << speed_sel_q;
    // A speed change in the same cycle suppresses the terminal count.
    assign term    = (state_q == ST_RUN) && (presc_q == divisor - 32'd1) && !spd_rise;

    always_comb begin
        state_d = state_q;
        if (rst_lvl || cpu_rst_q) begin
            state_d = ST_PAUSE;
        end else begin
            case (state_q)
                ST_PAUSE: begin
                    if (go_lvl) begin
                        state_d = ST_RUN;
                    end else if (step_rise) begin
                        state_d = ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (!go_lvl) begin
                        state_d = ST_PAUSE;
                    end
                end
                default: state_d = ST_PAUSE;
            endcase
        end

        presc_d = '0;
        if (state_q == ST_RUN && state_d == ST_RUN && !spd_rise && !cpu_rst_q) begin
            presc_d = term ? 32'd0 : presc_q + 32'd1;
        end

        speed_sel_d = spd_rise ? speed_sel_q + 2'd1 : speed_sel_q;
        cpu_ce_d    = rst_lvl || term || (state_q == ST_STEP);
        cpu_rst_d   = rst_lvl;
        running_d   = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            lvl_q       <= '0;
            lvl_prev_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= '0;
            end
            state_q     <= ST_PAUSE;
            presc_q     <= '0;
            speed_sel_q <= '0;
            cpu_ce_q    <= 1'b0;
            cpu_rst_q   <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            lvl_q       <= lvl_d;
            lvl_prev_q  <= lvl_prev_d;
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
            state_q     <= state_d;
            presc_q     <= presc_d;
            speed_sel_q <= speed_sel_d;
            cpu_ce_q    <= cpu_ce_d;
            cpu_rst_q   <= cpu_rst_d;
            running_q   <= running_d;
        end
    end

`ifdef CPU_CE_COUNT_EN
    logic [31:0] ce_count_q, ce_count_d;

    // Reset-hold enables are not real instruction cycles, so they are not counted.
    always_comb begin
        ce_count_d = ce_count_q;
        if (cpu_ce_q && !cpu_rst_q) begin
            ce_count_d = ce_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ce_count_q <= '0;
        end else begin
            ce_count_q <= ce_count_d;
        end
    end

    assign bus.ce_count = ce_count_q;
`else
    assign bus.ce_count = '0;
`endif

    assign bus.cpu_ce    = cpu_ce_q;
    assign bus.cpu_rst   = cpu_rst_q;
    assign bus.speed_sel = speed_sel_q;
    assign bus.running   = running_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed scenarios followed by randomized switch activity, all checked against a cycle reference model.
module tb_cpu_clk_ctrl;

    localparam int BASE = 4;
    localparam int DEB  = 3;
    localparam int M_PAUSE = 0;
    localparam int M_RUN   = 1;
    localparam int M_STEP  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    cpu_clk_ctrl_if bus ();

    cpu_clk_ctrl #(.BASE_DIV(BASE), .DEB_CYCLES(DEB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_mode;
    int unsigned m_phase;
    int          m_speed;
    bit          m_ce;
    bit          m_rst;
    bit [31:0]   m_cnt;
    bit          L [4];
    bit          R [4];
    bit [15:0]   hist [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_PAUSE;
        m_phase = 0;
        m_speed = 0;
        m_ce    = 1'b0;
        m_rst   = 1'b0;
        m_cnt   = '0;
        for (int i = 0; i < 4; i++) begin
            L[i]    = 1'b0;
            R[i]    = 1'b0;
            hist[i] = '0;
        end
    endtask

    task automatic model_edge();
        bit          raw [4];
        int          nm;
        int unsigned div;
        bit          term;
        bit          flip;
        bit          new_l;
        raw[0] = bus.sw_go;
        raw[1] = bus.sw_rst;
        raw[2] = bus.sw_speed;
        raw[3] = bus.btn_step;
        if (!rst_n) begin
            model_reset();
            return;
        end
        div  = BASE * (1 << m_speed);
        term = (m_mode == M_RUN) && (m_phase == div - 1) && !R[2];

        if (L[1] || m_rst)          nm = M_PAUSE;
        else if (m_mode == M_PAUSE) nm = L[0] ? M_RUN : (R[3] ? M_STEP : M_PAUSE);
        else if (m_mode == M_RUN)   nm = L[0] ? M_RUN : M_PAUSE;
        else                        nm = M_PAUSE;

`ifdef CPU_CE_COUNT_EN
        if (m_ce && !m_rst) m_cnt = m_cnt + 1;
`endif
        if (m_mode == M_RUN && nm == M_RUN && !R[2])
            m_phase = (m_phase + 1 == div) ? 0 : m_phase + 1;
        else
            m_phase = 0;
        if (R[2]) m_speed = (m_speed + 1) % 4;
        m_ce   = L[1] || term || (m_mode == M_STEP);
        m_rst  = L[1];
        m_mode = nm;

        // Accepted level flips once the last DEB synchronised samples all disagree with it.
        for (int i = 0; i < 4; i++) begin
            flip = 1'b1;
            for (int k = 1; k <= DEB; k++) begin
                if (hist[i][k] == L[i]) flip = 1'b0;
            end
            new_l   = flip ? !L[i] : L[i];
            R[i]    = new_l && !L[i];
            L[i]    = new_l;
            hist[i] = {hist[i][14:0], raw[i]};
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("cpu_ce",    32'(bus.cpu_ce),    32'(m_ce));
        chk("cpu_rst",   32'(bus.cpu_rst),   32'(m_rst));
        chk("speed_sel", 32'(bus.speed_sel), 32'(m_speed));
        chk("running",   32'(bus.running),   32'(m_mode == M_RUN));
        chk("ce_count",  bus.ce_count,       m_cnt);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_ce(input int budget, output int n);
        n = 0;
        tick();
        n++;
        while (bus.cpu_ce !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("ce_seen", 32'(bus.cpu_ce), 32'd1);
    endtask

    task automatic count_ce(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            tick();
            if (bus.cpu_ce === 1'b1) cnt++;
        end
    endtask

    task automatic measure_spacing(input int exp, input int npulse, input string tag);
        int n;
        wait_ce(300, n);
        for (int p = 0; p < npulse; p++) begin
            wait_ce(exp + 40, n);
            chk(tag, 32'(n), 32'(exp));
        end
    endtask

    initial begin
        int c, c1, c2, total, n, sel;
        bit [31:0] saved;
        bus.sw_go    = 1'b0;
        bus.sw_rst   = 1'b0;
        bus.sw_speed = 1'b0;
        bus.btn_step = 1'b0;
        model_reset();

        // 1: reset state and idle
        rst_n = 1'b0;
        run(2);
        chk("rst_cpu_ce",    32'(bus.cpu_ce),    32'd0);
        chk("rst_cpu_rst",   32'(bus.cpu_rst),   32'd0);
        chk("rst_speed_sel", 32'(bus.speed_sel), 32'd0);
        chk("rst_running",   32'(bus.running),   32'd0);
        chk("rst_ce_count",  bus.ce_count,       32'd0);
        rst_n = 1'b1;
        count_ce(50, c);
        chk("idle_no_ce", 32'(c), 32'd0);

        // 2: run at base rate
        bus.sw_go = 1'b1;
        run(5);
        chk("run_not_yet", 32'(bus.running), 32'd0);
        tick();
        chk("run_after_6", 32'(bus.running), 32'd1);
        wait_ce(20, n);
        chk("first_ce_latency", 32'(n), 32'd4);
        for (int p = 0; p < 4; p++) begin
            wait_ce(20, n);
            chk("spacing_x1", 32'(n), 32'd4);
        end
        tick();
`ifdef CPU_CE_COUNT_EN
        chk("ce_count_5", bus.ce_count, 32'd5);
`else
        chk("ce_count_off", bus.ce_count, 32'd0);
`endif

        // 3: speed steps 1,2,3 then wrap to 0
        for (int s = 1; s <= 4; s++) begin
            bus.sw_speed = 1'b1;
            run(8);
            bus.sw_speed = 1'b0;
            run(8);
            sel = s % 4;
            chk("speed_sel_step", 32'(bus.speed_sel), 32'(sel));
            measure_spacing(BASE << sel, 2, "speed_spacing");
        end

        // 4: single steps while paused, then a step press while running
        bus.sw_go = 1'b0;
        run(12);
        total = 0;
        for (int k = 0; k < 4; k++) begin
            bus.btn_step = 1'b1;
            count_ce(8, c1);
            bus.btn_step = 1'b0;
            count_ce(8, c2);
            total += c1 + c2;
        end
        chk("step_pulses", 32'(total), 32'd4);
        bus.sw_go = 1'b1;
        run(10);
        wait_ce(40, n);
        bus.btn_step = 1'b1;
        count_ce(16, c);
        bus.btn_step = 1'b0;
        chk("run_step_ignored", 32'(c), 32'd4);

        // 5: bouncing step button while paused
        bus.sw_go = 1'b0;
        run(14);
        total = 0;
        bus.btn_step = 1'b1; count_ce(2, c); total += c;
        bus.btn_step = 1'b0; count_ce(2, c); total += c;
        bus.btn_step = 1'b1; count_ce(2, c); total += c;
        bus.btn_step = 1'b0; count_ce(20, c); total += c;
        chk("bounce_no_ce", 32'(total), 32'd0);

        // 6: CPU reset while running, then release into run
        bus.sw_go = 1'b1;
        run(10);
        wait_ce(40, n);
        bus.sw_rst = 1'b1;
        run(6);
        saved = m_cnt;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("hold_cpu_rst",  32'(bus.cpu_rst), 32'd1);
            chk("hold_cpu_ce",   32'(bus.cpu_ce),  32'd1);
            chk("hold_running",  32'(bus.running), 32'd0);
            chk("hold_ce_count", bus.ce_count,     saved);
        end
        bus.sw_rst = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.running !== 1'b1 && n < 20);
        chk("run_after_rst", 32'(bus.running), 32'd1);
        wait_ce(20, n);
        chk("first_ce_after_rst", 32'(n), 32'd4);

        // 7: randomized switch activity including occasional board reset
        repeat (400) begin
            if ($urandom_range(0, 2) == 0) bus.sw_go    = ~bus.sw_go;
            if ($urandom_range(0, 5) == 0) bus.sw_rst   = ~bus.sw_rst;
            if ($urandom_range(0, 3) == 0) bus.sw_speed = ~bus.sw_speed;
            if ($urandom_range(0, 2) == 0) bus.btn_step = ~bus.btn_step;
            rst_n = ($urandom_range(0, 60) != 0);
            run($urandom_range(1, 12));
            rst_n = 1'b1;
        end
        run(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
